// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback scheduler and its arbiter.
package wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int WB_DATA_W = 32;

    localparam int WB_ALU = 0;
    localparam int WB_MEM = 1;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/writeback_scheduler_if.sv
// Decode-issue, writeback-request and register-file signals of the scheduler.
interface writeback_scheduler_if
    import wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int STALL_CNT_W = 16
);
    logic                          issue_valid;
    logic [REG_IDX_W-1:0]          issue_rs1;
    logic [REG_IDX_W-1:0]          issue_rs2;
    logic                          issue_use_rs1;
    logic                          issue_use_rs2;
    logic [REG_IDX_W-1:0]          issue_rd;
    logic                          issue_wr_rd;
    logic                          issue_ready;

    logic [1:0]                    wb_valid;
    logic [1:0][REG_IDX_W-1:0]     wb_rd;
    logic [1:0][XLEN-1:0]          wb_data;
    logic [1:0]                    wb_ready;

    logic                          rf_we;
    logic [REG_IDX_W-1:0]          rf_waddr;
    logic [XLEN-1:0]               rf_wdata;
    logic [NREG-1:0]               busy;
    logic [STALL_CNT_W-1:0]        stall_cnt;
    logic                          err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_wr_rd, wb_valid, wb_rd, wb_data,
        input  issue_ready, wb_ready, rf_we, rf_waddr, rf_wdata, busy,
               stall_cnt, err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_wr_rd, wb_valid, wb_rd, wb_data,
        output issue_ready, wb_ready, rf_we, rf_waddr, rf_wdata, busy,
               stall_cnt, err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot combinational grant, pointer flips only
// on a contended grant so a lone requester never disturbs the fairness order.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic rr_ptr_reg;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                grant = rr_ptr_reg ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else if (req == 2'b11) begin
            rr_ptr_reg <= ~rr_ptr_reg;
        end
    end

endmodule

// File: rtl/writeback_scheduler.sv
// Owns the register-file write port: busy scoreboard with RAW/WAW issue stall,
// round-robin writeback arbitration and registered write-port outputs.
module writeback_scheduler
    import wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    writeback_scheduler_if.slave  bus
);

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;

    logic [NREG-1:0]        busy_reg;
    logic [NREG-1:0]        busy_next;
    logic                   rf_we_reg;
    logic [REG_IDX_W-1:0]   rf_waddr_reg;
    logic [XLEN-1:0]        rf_wdata_reg;
    logic [STALL_CNT_W-1:0] stall_reg;
    logic                   err_reg;

    logic                   raw;
    logic                   waw;
    logic                   issue_ready;
    logic                   issue_fire;
    logic [1:0]             grant;
    logic                   grant_any;
    wb_req_t                req [2];
    wb_req_t                granted;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req[gi].valid = bus.wb_valid[gi];
        assign req[gi].rd    = bus.wb_rd[gi];
        assign req[gi].data  = bus.wb_data[gi];
    end

    assign raw = (bus.issue_use_rs1 && busy_reg[bus.issue_rs1]) ||
                 (bus.issue_use_rs2 && busy_reg[bus.issue_rs2]);
    assign waw = bus.issue_wr_rd && busy_reg[bus.issue_rd];

    assign issue_ready = !i_rst && !raw && !waw;
    assign issue_fire  = bus.issue_valid && issue_ready && bus.issue_wr_rd &&
                         (bus.issue_rd != '0);

    rr_arbiter2 u_arb (
        .clk   (i_clk),
        .rst   (i_rst),
        .req   (bus.wb_valid),
        .grant (grant)
    );

    assign grant_any = |grant;
    assign granted   = grant[WB_MEM] ? req[WB_MEM] : req[WB_ALU];

    // A set and a clear of the same index cannot coincide (WAW holds the
    // issue), but if it ever did the set is applied last and wins.
    always_comb begin
        busy_next = busy_reg;
        if (rf_we_reg) begin
            busy_next[rf_waddr_reg] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_reg     <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            stall_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            busy_reg  <= busy_next;
            rf_we_reg <= grant_any && granted.valid && (granted.rd != '0);
            if (grant_any) begin
                rf_waddr_reg <= granted.rd;
                rf_wdata_reg <= granted.data[XLEN-1:0];
            end
            if (bus.issue_valid && !issue_ready && !(&stall_reg)) begin
                stall_reg <= stall_reg + STALL_ONE;
            end
            // The write that is retiring must have a matching in-flight owner.
            if (rf_we_reg && !busy_reg[rf_waddr_reg]) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.wb_ready    = grant;
    assign bus.rf_we       = rf_we_reg;
    assign bus.rf_waddr    = rf_waddr_reg;
    assign bus.rf_wdata    = rf_wdata_reg;
    assign bus.busy        = busy_reg;
    assign bus.stall_cnt   = stall_reg;
    assign bus.err         = err_reg;

endmodule

// File: doc/writeback_scheduler.md
Name: writeback_scheduler

Overview:
- Sits between the decode stage and the execution units; owns the single register-file write port.
- Keeps a per-register busy scoreboard and stalls decode issue on RAW/WAW hazards against in-flight writes.
- Arbitrates write-port access between two writeback requesters, ALU (port 0) and MEM (port 1), using round-robin.
- Drives the register file's write index, data and enable from registered outputs.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers; index width is $clog2(NREG).
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_issue_valid  in  1  decode has an instruction to issue.
- i_issue_rs1  in  5  source register 1 index.
- i_issue_rs2  in  5  source register 2 index.
- i_issue_use_rs1  in  1  instruction reads rs1.
- i_issue_use_rs2  in  1  instruction reads rs2.
- i_issue_rd  in  5  destination register index.
- i_issue_wr_rd  in  1  instruction writes rd.
- o_issue_ready  out  1  issue accepted this cycle when high together with i_issue_valid.
- i_wb_valid  in  2  writeback request, per port.
- i_wb_rd  in  2x5  destination index, per port.
- i_wb_data  in  2xXLEN  writeback data, per port.
- o_wb_ready  out  2  one-hot grant; request consumed when valid and ready are both high.
- o_rf_we  out  1  register-file write enable (registered).
- o_rf_waddr  out  5  register-file write index (registered).
- o_rf_wdata  out  XLEN  register-file write data (registered).
- o_busy  out  NREG  scoreboard vector, debug only.
- o_stall_cnt  out  STALL_CNT_W  saturating count of hazard-stalled cycles.
- o_err  out  1  sticky: a writeback was granted to a non-busy register.

Behaviour:
- Reset, synchronous on i_rst: busy=0, rr_ptr=0 (port 0 preferred), o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_stall_cnt=0, o_err=0.
- While i_rst is high, o_issue_ready=0 and o_wb_ready=0.
- Reset mid-operation discards all pending state; there is no drain.
- Hazard checks are combinational on the current busy vector:
  - raw = (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]).
  - waw = wr_rd && busy[rd].
  - o_issue_ready = !raw && !waw.
- busy[0] is hardwired to 0, so x0 never stalls or marks busy.
- Issue fire (valid && ready && wr_rd && rd!=0): busy[rd] is set at the next edge.
- Arbitration:
  - Single request: that port is granted.
  - Both requesting: the port indicated by rr_ptr is granted, and rr_ptr toggles to the other port on every two-way contention grant.
  - A single-requester grant leaves rr_ptr unchanged.
  - o_wb_ready is combinational, at most one bit high, and never high without the matching valid.
- Writeback pipeline:
  - Grant in cycle G latches rd/data into the o_rf_* registers.
  - o_rf_we=1 in cycle G+1 only; it is forced to 0 when rd==0.
  - busy[o_rf_waddr] clears at the end of G+1, the same edge on which the register file writes.
  - A dependent issue becomes ready in G+2 and reads the updated value, so no bypass is required.
  - Minimum latency from grant to unstall is 2 cycles.
- Simultaneous events:
  - Setting busy[a] and clearing busy[b] in the same cycle with a!=b: both apply.
  - a==b cannot occur because the WAW check holds the issue; the assertion is that the set wins.
- Error: the clearing cycle with o_rf_we=1 and busy[o_rf_waddr]==0 sets o_err. Only i_rst clears it.
- Stall counter: increments when i_issue_valid && !o_issue_ready, and saturates at all-ones.
- Throughput: one write-port grant per cycle, with no bubbles between back-to-back grants.

Decomposition:
- Shared package wb_pkg holds:
  - the REG_IDX_W localparam;
  - the port-index constants WB_ALU=0 and WB_MEM=1;
  - a wb_req_t struct {valid, rd, data}.
- One sub-module: rr_arbiter2. It is a 2-way round-robin with the rr_ptr register and a one-hot grant, reusable elsewhere.
- The scoreboard, hazard logic and output registers stay in the top level.

Test Plan:
- Reset with i_rst=1 for 2 cycles, then issue rd=5 → busy=0 after reset; o_issue_ready=1; busy[5]=1 the next cycle; o_rf_we=0 throughout reset.
- RAW stall: issue rd=5, then an instruction using rs1=5 → ready=0 and stall_cnt increments each cycle. ALU writeback rd=5 data=0xDEADBEEF granted in G → o_rf_we=1, waddr=5, wdata=0xDEADBEEF in G+1; ready=1 in G+2; stall_cnt equals the number of stalled cycles.
- WAW: rd=7 busy, issue wr_rd rd=7 with no sources → ready=0 until the writeback of rd=7 clears; wr_rd=0 with rd=7 → ready=1.
- Contention: both ports valid for 4 cycles (ALU rd=1..4, MEM rd=9..12, all busy) → grants alternate ALU, MEM, ALU, MEM, one per cycle; o_rf_waddr sequence 1, 9, 2, 10.
- x0 handling: issue rd=0 → busy unchanged. Writeback rd=0 → granted, o_rf_we=0, o_err stays 0.
- Error and saturation: writeback rd=3 while not busy → o_err=1 in G+2 and stays set. With STALL_CNT_W=4, hold a stall for 20 cycles → o_stall_cnt=15.
